mem_burst_ctrl: RTL and testbench

//  Initiator for the calculator's word-addressed operand/result memory bank.

---
 rtl/calc_mem_pkg.sv | 17 +
 rtl/mem_burst_ctrl_if.sv | 43 ++++
 rtl/mem_addr_wrap.sv | 27 ++
 rtl/mem_burst_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_mem_pkg.sv
// Shared types for the calculator memory-bank burst initiator.
// Holds the controller state encoding and the memory R_W bus encoding.
// No logic; imported by mem_burst_ctrl.
package calc_mem_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        READ       = 3'd2,
        VERIFY_RD  = 3'd3,
        VERIFY_CMP = 3'd4
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Bundle of request, write-beat, read-return and memory-bus signals for mem_burst_ctrl.
// master: the burst controller side; slave: datapath + memory side (testbench).
// Pure wiring, no latency, no storage.
interface mem_burst_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    // request channel
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqRW;
    logic [ADDR_W-1:0] ReqAddr;
    logic [LEN_W-1:0]  ReqLen;
    // write beats
    logic [DATA_W-1:0] WrData;
    logic              WrValid;
    logic              WrReady;
    // read return and status
    logic [DATA_W-1:0] RdData;
    logic              RdValid;
    logic              Busy;
    logic              Done;
    logic              VerifyErr;
    // memory bus
    logic              MemValid;
    logic              MemRW;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemDin;
    logic [DATA_W-1:0] MemDout;

    modport master (
        input  ReqValid, ReqRW, ReqAddr, ReqLen, WrData, WrValid, MemDout,
        output ReqReady, WrReady, RdData, RdValid, Busy, Done, VerifyErr,
               MemValid, MemRW, MemAddr, MemDin
    );

    modport slave (
        output ReqValid, ReqRW, ReqAddr, ReqLen, WrData, WrValid, MemDout,
        input  ReqReady, WrReady, RdData, RdValid, Busy, Done, VerifyErr,
               MemValid, MemRW, MemAddr, MemDin
    );
endinterface

// File: rtl/mem_addr_wrap.sv
// Loadable word-address counter that wraps DEPTH-1 -> 0.
// Latency: new value visible the cycle after load/inc; load has priority over inc.
// No backpressure; advances only when inc is asserted.
// Ports: clk, rst_n (async active-low), load/load_val, inc, addr.
module mem_addr_wrap #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (inc) begin
            addr <= (addr == LAST) ? '0 : addr + 1'b1;
        end
    end
endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst initiator: turns (rw, addr, len) requests into one memory access per cycle with wrap.
// Latency: memory command combinational from state; read data returned 1 cycle after issue.
// Backpressure: writes stall on WrValid low; reads never stall; ReqReady only in IDLE.
// Ports: Clk, Reset (async active-low), bus (mem_burst_ctrl_if.master: Req*, Wr*, Rd*, Busy,
//        Done, VerifyErr, Mem*). Optional macro READBACK_VERIFY_EN adds a readback compare
//        after every write beat; without it VerifyErr is tied 0.
module mem_burst_ctrl
    import calc_mem_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic Clk,
    input  logic Reset,
    mem_burst_ctrl_if.master bus
);
    state_t            state, state_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr;
    logic              addr_load, addr_inc;
    logic              last_beat;
    logic              rd_issue;
    logic              rd_vld_q, rd_last_q;
    logic              wr_done;

    mem_addr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (addr_load),
        .load_val (bus.ReqAddr),
        .inc      (addr_inc),
        .addr     (addr)
    );

    // beat counter holds beats-remaining-minus-one, so zero means this is the last beat
    assign last_beat = (cnt == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_vld_q  <= rd_issue;
            rd_last_q <= rd_issue & last_beat;
        end
    end

`ifdef READBACK_VERIFY_EN
    logic [DATA_W-1:0] wdat_hold;
    logic              verify_err, verify_err_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wdat_hold  <= '0;
            verify_err <= 1'b0;
        end else begin
            verify_err <= verify_err_nxt;
            if (state == WRITE && bus.WrValid) begin
                wdat_hold <= bus.WrData;
            end
        end
    end

    assign bus.VerifyErr = verify_err;
`else
    assign bus.VerifyErr = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_load    = 1'b0;
        addr_inc     = 1'b0;
        rd_issue     = 1'b0;
        wr_done      = 1'b0;
        bus.ReqReady = 1'b0;
        bus.WrReady  = 1'b0;
        bus.MemValid = 1'b0;
        bus.MemRW    = MEM_READ;
        bus.MemAddr  = '0;
        bus.MemDin   = '0;
`ifdef READBACK_VERIFY_EN
        verify_err_nxt = verify_err;
`endif
        case (state)
            IDLE: begin
                bus.ReqReady = 1'b1;
                if (bus.ReqValid) begin
                    addr_load = 1'b1;
                    cnt_nxt   = bus.ReqLen;
                    state_nxt = (bus.ReqRW == MEM_WRITE) ? WRITE : READ;
`ifdef READBACK_VERIFY_EN
                    verify_err_nxt = 1'b0;
`endif
                end
            end
            WRITE: begin
                bus.WrReady  = 1'b1;
                bus.MemValid = bus.WrValid;
                bus.MemRW    = MEM_WRITE;
                bus.MemAddr  = addr;
                bus.MemDin   = bus.WrData;
                if (bus.WrValid) begin
`ifdef READBACK_VERIFY_EN
                    // address advances after the readback, count after the compare
                    state_nxt = VERIFY_RD;
`else
                    addr_inc  = 1'b1;
                    wr_done   = last_beat;
                    cnt_nxt   = last_beat ? cnt : cnt - 1'b1;
                    state_nxt = last_beat ? IDLE : WRITE;
`endif
                end
            end
            READ: begin
                bus.MemValid = 1'b1;
                bus.MemAddr  = addr;
                rd_issue     = 1'b1;
                addr_inc     = 1'b1;
                cnt_nxt      = last_beat ? cnt : cnt - 1'b1;
                state_nxt    = last_beat ? IDLE : READ;
            end
`ifdef READBACK_VERIFY_EN
            VERIFY_RD: begin
                bus.MemValid = 1'b1;
                bus.MemAddr  = addr;
                addr_inc     = 1'b1;
                state_nxt    = VERIFY_CMP;
            end
            VERIFY_CMP: begin
                if (bus.MemDout != wdat_hold) begin
                    verify_err_nxt = 1'b1;
                end
                wr_done   = last_beat;
                cnt_nxt   = last_beat ? cnt : cnt - 1'b1;
                state_nxt = last_beat ? IDLE : WRITE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.RdValid = rd_vld_q;
    assign bus.RdData  = bus.MemDout;
    assign bus.Busy    = (state != IDLE);
    // read completion is seen one cycle after issue, when the last beat's data returns
    assign bus.Done    = wr_done | (rd_vld_q & rd_last_q);
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: directed bursts, scoreboard monitor on memory bus
// and read-return channel, plus a registered-read memory model.
module tb_mem_burst_ctrl;
    logic Clk;
    logic Reset;

    mem_burst_ctrl_if #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) bus ();

    mem_burst_ctrl #(.DEPTH(8), .ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // memory model: registered read, corrupts readback of address 5 when verify is built in
    logic [31:0] mem [0:7];
    logic [31:0] dout;
    assign bus.MemDout = dout;

    always @(posedge Clk) begin
        if (bus.MemValid) begin
            if (bus.MemRW) begin
                mem[bus.MemAddr[2:0]] <= bus.MemDin;
            end else begin
`ifdef READBACK_VERIFY_EN
                dout <= mem[bus.MemAddr[2:0]] ^ ((bus.MemAddr == 8'd5) ? 32'h1 : 32'h0);
`else
                dout <= mem[bus.MemAddr[2:0]];
`endif
            end
        end
    end

    typedef struct packed {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] din;
    } acc_t;

    acc_t        exp_mem [$];
    logic [31:0] exp_rd  [$];
    logic [31:0] shadow  [0:7];
    logic [31:0] wbuf    [0:15];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tfail(input string name);
        total++;
        $display("FAIL %s: event did not occur within bound at %0t", name, $time);
    endtask

    function automatic int nxt(input int a);
        return (a == 7) ? 0 : a + 1;
    endfunction

    // scoreboard monitor, sampling on the falling edge
    initial begin
        acc_t e;
        forever begin
            @(negedge Clk);
            if (bus.MemValid === 1'b1) begin
                if (exp_mem.size() == 0) begin
                    total++;
                    $display("FAIL mem_unexpected: access rw=%0b addr=%0d, expected none", bus.MemRW, bus.MemAddr);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_rw", 32'(bus.MemRW), 32'(e.rw));
                    chk("mem_addr", 32'(bus.MemAddr), 32'(e.addr));
                    if (e.rw) chk("mem_din", bus.MemDin, e.din);
                end
            end
            if (bus.RdValid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    $display("FAIL rd_unexpected: data %h, expected no RdValid", bus.RdData);
                end else begin
                    chk("rd_data", bus.RdData, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // all tasks begin and end 1 time unit after a rising edge
    task automatic issue_req(input logic rw, input int a, input int len);
        int g = 0;
        while (bus.Busy && g < 50) begin @(posedge Clk); #1; g++; end
        if (g == 50) tfail("wait_idle");
        bus.ReqValid = 1'b1;
        bus.ReqRW    = rw;
        bus.ReqAddr  = 8'(a);
        bus.ReqLen   = 4'(len);
        @(negedge Clk);
        chk("req_ready", 32'(bus.ReqReady), 32'd1);
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        chk("busy_after_accept", 32'(bus.Busy), 32'd1);
        chk("verify_err_cleared", 32'(bus.VerifyErr), 32'd0);
    endtask

    task automatic do_write(input int a, input int len, input int stall_at, input int stall_n);
        int ad = a;
        int g;
        issue_req(1'b1, a, len);
        for (int b = 0; b <= len; b++) begin
            g = 0;
            while (!bus.WrReady && g < 10) begin @(posedge Clk); #1; g++; end
            if (g == 10) tfail("wr_ready");
            if (b == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge Clk);
                    chk("stall_mem_valid", 32'(bus.MemValid), 32'd0);
                    @(posedge Clk); #1;
                end
            end
            bus.WrValid = 1'b1;
            bus.WrData  = wbuf[b];
            exp_mem.push_back('{rw: 1'b1, addr: 8'(ad), din: wbuf[b]});
`ifdef READBACK_VERIFY_EN
            exp_mem.push_back('{rw: 1'b0, addr: 8'(ad), din: 32'h0});
`endif
            shadow[ad] = wbuf[b];
            ad = nxt(ad);
            @(negedge Clk);
`ifdef READBACK_VERIFY_EN
            chk("wr_done", 32'(bus.Done), 32'd0);
`else
            chk("wr_done", 32'(bus.Done), (b == len) ? 32'd1 : 32'd0);
`endif
            @(posedge Clk); #1;
            bus.WrValid = 1'b0;
        end
`ifdef READBACK_VERIFY_EN
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("verify_done", 32'(bus.Done), 32'd1);
        @(posedge Clk); #1;
`endif
        chk("busy_after_write", 32'(bus.Busy), 32'd0);
    endtask

    task automatic do_read(input int a, input int len, input int abort_at);
        int ad = a;
        issue_req(1'b0, a, len);
        for (int b = 0; b <= len; b++) begin
            if (b == abort_at) begin
                Reset = 1'b0;
                #1;
                chk("rst_mem_valid", 32'(bus.MemValid), 32'd0);
                chk("rst_mem_addr", 32'(bus.MemAddr), 32'd0);
                chk("rst_req_ready", 32'(bus.ReqReady), 32'd1);
                chk("rst_busy", 32'(bus.Busy), 32'd0);
                chk("rst_rd_valid", 32'(bus.RdValid), 32'd0);
                chk("rst_done", 32'(bus.Done), 32'd0);
                // the beat issued last cycle is dropped by reset
                exp_rd.delete();
                @(posedge Clk); #1;
                Reset = 1'b1;
                @(negedge Clk);
                chk("post_rst_rd_valid", 32'(bus.RdValid), 32'd0);
                @(posedge Clk); #1;
                return;
            end
            exp_mem.push_back('{rw: 1'b0, addr: 8'(ad), din: 32'h0});
            exp_rd.push_back(shadow[ad]);
            ad = nxt(ad);
            @(negedge Clk);
            chk("rd_busy", 32'(bus.Busy), 32'd1);
            chk("rd_done_early", 32'(bus.Done), 32'd0);
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        chk("rd_trail_valid", 32'(bus.RdValid), 32'd1);
        chk("rd_done", 32'(bus.Done), 32'd1);
        chk("rd_busy_low", 32'(bus.Busy), 32'd0);
        @(posedge Clk); #1;
    endtask

    initial begin
        Reset        = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqRW    = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqLen   = '0;
        bus.WrValid  = 1'b0;
        bus.WrData   = '0;
        dout         = '0;
        for (int i = 0; i < 8; i++) begin shadow[i] = '0; mem[i] = '0; end
        #1;
        chk("reset_req_ready", 32'(bus.ReqReady), 32'd1);
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        chk("reset_mem_valid", 32'(bus.MemValid), 32'd0);
        chk("reset_rd_valid", 32'(bus.RdValid), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);
        chk("reset_wr_ready", 32'(bus.WrReady), 32'd0);
        chk("reset_verify_err", 32'(bus.VerifyErr), 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;

        // 1: write A,B,C to 2..4; 2: read them back
        wbuf[0] = 32'hA000_000A; wbuf[1] = 32'hB000_000B; wbuf[2] = 32'hC000_000C;
        do_write(2, 2, -1, 0);
        do_read(2, 2, -1);

        // 3: wrapping burst 6,7,0,1
        wbuf[0] = 32'h6666_0006; wbuf[1] = 32'h7777_0007; wbuf[2] = 32'h0000_1000; wbuf[3] = 32'h1111_0001;
        do_write(6, 3, -1, 0);
        do_read(6, 3, -1);

        // 4: two-cycle stall before beat 2 of a 4-beat write at 0..3
        wbuf[0] = 32'hD000_0000; wbuf[1] = 32'hD000_0001; wbuf[2] = 32'hD000_0002; wbuf[3] = 32'hD000_0003;
        do_write(0, 3, 2, 2);
        do_read(0, 3, -1);

        // 5: reset during beat 2 of a 4-beat read, then a fresh request still works
        do_read(0, 3, 2);
        do_read(2, 0, -1);

`ifdef READBACK_VERIFY_EN
        // 6: readback of address 5 is corrupted by the memory model
        wbuf[0] = 32'h5555_AAAA;
        do_write(5, 0, -1, 0);
        chk("verify_err_set", 32'(bus.VerifyErr), 32'd1);
        do_read(3, 0, -1);
`endif

        repeat (3) @(posedge Clk);
        #1;
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
